// File: rtl/trng_multi_sampler_if.sv
// Output stream of the TRNG sampler: FIFO head word with valid/ready handshake.
//   out_data  : head word (WIDTH bits), driven by master
//   out_valid : head word present, driven by master
//   out_ready : consumer accepts head, driven by slave
interface trng_multi_sampler_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/trng_multi_sampler.sv
// Multi-channel ring-oscillator sampler: synchronises NUM_CH RO outputs, samples
// them on a programmable tick, XOR-combines the enabled channels, optionally
// debiases (von Neumann / XOR pair), packs bits into WIDTH-bit words and buffers
// them in a first-word-fall-through FIFO guarded by a repetition-count test.
// Ports:
//   clk, rst_n   : clock; rst_n is a synchronous ACTIVE-HIGH reset
//   ro_in, ch_en : raw RO outputs (async) and per-channel enables
//   mode         : 0/3 raw, 1 von Neumann, 2 XOR pair
//   sample_div   : sample tick every sample_div+1 clocks
//   out_if       : word stream (out_data/out_valid/out_ready)
//   fifo_count   : FIFO occupancy
//   overflow     : sticky, a word was dropped on a full FIFO
//   health_fail  : sticky, repetition-count test tripped
module trng_multi_sampler #(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned RCT_LIMIT = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_CH-1:0]          ro_in,
  input  logic [NUM_CH-1:0]          ch_en,
  input  logic [1:0]                 mode,
  input  logic [7:0]                 sample_div,
  trng_multi_sampler_if.master       out_if,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       overflow,
  output logic                       health_fail
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam int unsigned BW = $clog2(WIDTH);
  localparam int unsigned RW = $clog2(RCT_LIMIT+1);
  localparam logic [1:0] MODE_VN  = 2'd1;
  localparam logic [1:0] MODE_XOR = 2'd2;

  logic [NUM_CH-1:0] sync1, sync2;
  logic [7:0]        div_cnt;
  logic [1:0]        mode_q;
  logic              pair_vld, pair_bit;
  logic [WIDTH-1:0]  shreg;
  logic [BW-1:0]     bit_cnt;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [AW-1:0]     wptr, rptr;
  logic [CW-1:0]     count;
  logic [RW-1:0]     run_cnt;
  logic              prev_b;

  logic              tick_c, accept_c, samp_c, mode_chg_c;
  logic              emit_c, ebit_c, word_done_c, push_c, pop_c;
  logic [WIDTH-1:0]  word_c;
  logic [RW-1:0]     run_nxt_c;

  // Sample qualification and combined bit
  assign tick_c     = (div_cnt == sample_div);
  assign accept_c   = tick_c && (|ch_en);
  assign samp_c     = ^(sync2 & ch_en);
  assign mode_chg_c = (mode != mode_q);

  // Conditioning: a sample coinciding with a mode change is not packed
  always_comb begin
    emit_c = 1'b0;
    ebit_c = samp_c;
    if (accept_c && !mode_chg_c) begin
      case (mode_q)
        MODE_VN: begin
          emit_c = pair_vld && (pair_bit != samp_c);
          ebit_c = pair_bit;
        end
        MODE_XOR: begin
          emit_c = pair_vld;
          ebit_c = pair_bit ^ samp_c;
        end
        default: emit_c = 1'b1;
      endcase
    end
  end

  assign word_done_c = emit_c && (bit_cnt == BW'(WIDTH-1));
  assign word_c      = {shreg[WIDTH-2:0], ebit_c};
  assign pop_c       = (count != '0) && out_if.out_ready;
  assign push_c      = word_done_c && !health_fail && ((count < CW'(DEPTH)) || pop_c);

  // Repetition run length, saturating at the limit
  always_comb begin
    run_nxt_c = RW'(1);
    if (run_cnt != '0 && samp_c == prev_b)
      run_nxt_c = (run_cnt == RW'(RCT_LIMIT)) ? run_cnt : run_cnt + RW'(1);
  end

  // Synchroniser, divider and registered mode
  always_ff @(posedge clk) begin
    if (rst_n) begin
      sync1   <= '0;
      sync2   <= '0;
      div_cnt <= '0;
      mode_q  <= '0;
    end else begin
      sync1   <= ro_in;
      sync2   <= sync1;
      div_cnt <= tick_c ? 8'd0 : div_cnt + 8'd1;
      mode_q  <= mode;
    end
  end

  // Pair state for the debiasing modes
  always_ff @(posedge clk) begin
    if (rst_n || mode_chg_c) begin
      pair_vld <= 1'b0;
      pair_bit <= 1'b0;
    end else if (accept_c && (mode_q == MODE_VN || mode_q == MODE_XOR)) begin
      pair_vld <= !pair_vld;
      pair_bit <= samp_c;
    end
  end

  // Bit packer: first bit of a word ends at the MSB
  always_ff @(posedge clk) begin
    if (rst_n || mode_chg_c) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (emit_c) begin
      shreg   <= word_c;
      bit_cnt <= word_done_c ? '0 : bit_cnt + BW'(1);
    end
  end

  // FIFO storage, pointers, occupancy and overflow flag
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_c) begin
        mem[wptr] <= word_c;
        wptr      <= wptr + AW'(1);
      end
      if (pop_c) rptr <= rptr + AW'(1);
      if (push_c && !pop_c)      count <= count + CW'(1);
      else if (pop_c && !push_c) count <= count - CW'(1);
      if (word_done_c && !health_fail && !push_c) overflow <= 1'b1;
    end
  end

  // Repetition-count health test on every accepted combined sample
  always_ff @(posedge clk) begin
    if (rst_n) begin
      run_cnt     <= '0;
      prev_b      <= 1'b0;
      health_fail <= 1'b0;
    end else if (accept_c) begin
      run_cnt <= run_nxt_c;
      prev_b  <= samp_c;
      if (run_nxt_c == RW'(RCT_LIMIT)) health_fail <= 1'b1;
    end
  end

  assign out_if.out_data  = mem[rptr];
  assign out_if.out_valid = (count != '0);
  assign fifo_count       = count;
endmodule

// File: doc/trng_multi_sampler.md
Name: trng_multi_sampler

Overview:
- Parametrised successor to the two-oscillator buffer counter.
- Samples NUM_CH free-running ring-oscillator outputs on a programmable tick and XOR-combines the enabled channels.
- Optionally debiases the bit stream, packs bits into WIDTH-bit words and buffers them in a DEPTH-entry FIFO with valid/ready output.
- Sits between the RO bank and the tile output mux; includes a repetition-count health test.

Parameters:
- NUM_CH, 2, number of ring-oscillator channels.
- WIDTH, 8, output word width in bits (>=2).
- DEPTH, 4, FIFO entries (power of 2, >=2).
- RCT_LIMIT, 32, consecutive identical samples that trip the health test (>=2).

Ports:
- clk  in  1  single system clock.
- rst_n  in  1  reset; synchronous, active-high despite the name (top level drives ~rst_n).
- ro_in  in  NUM_CH  asynchronous RO outputs.
- ch_en  in  NUM_CH  per-channel sample enable.
- mode  in  2  0=RAW, 1=VON_NEUMANN, 2=XOR_PAIR, 3=RAW.
- sample_div  in  8  tick every sample_div+1 clocks.
- out_data  out  WIDTH  FIFO head word.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts head.
- fifo_count  out  $clog2(DEPTH+1)  occupancy.
- overflow  out  1  sticky: word dropped on full FIFO.
- health_fail  out  1  sticky: repetition test tripped.

Behaviour:
- Reset (rst_n=1 at clk edge) clears:
  - synchronisers, divider, pair state, shift register and bit counter;
  - FIFO pointers and contents, run counter, overflow and health_fail.
  - All outputs read 0 after reset.
- Sync: two-flop synchroniser per ro_in bit. Samples see a 2-cycle latency.
- Divider:
  - cnt increments each cycle.
  - When cnt==sample_div: tick=1 and cnt returns to 0.
  - sample_div=0 gives a tick every cycle.
  - If sample_div is changed below the current cnt, cnt wraps at 8 bits; no special handling.
- Sample: on a tick with ch_en!=0, b = XOR-reduce(sync & ch_en). A tick with ch_en==0 is ignored (no bit, no health update).
- Conditioning, per accepted sample:
  - RAW (mode 0 or 3): emit b.
  - VON_NEUMANN: the first sample of a pair is stored. On the second sample, emit the first bit if the two differ, otherwise discard. Pair state then clears.
  - XOR_PAIR: emit first^second on every second sample.
- Mode change: registered mode is compared each cycle. On a change, clear pair state, shift register and bit counter. FIFO contents are kept.
- Packing:
  - Emitted bit shifts in at LSB; earlier bits move toward MSB (first bit of a word ends at MSB).
  - On the WIDTH-th bit, the word {shreg[WIDTH-2:0], bit} is offered to the FIFO in the same cycle and the bit counter returns to 0.
- FIFO:
  - First-word-fall-through: out_data=head and out_valid=(count!=0).
  - Pop when out_valid & out_ready.
  - Push when a word completes and health_fail==0, and either (count<DEPTH) or a pop occurs in the same cycle.
  - Simultaneous push and pop leaves the count unchanged.
  - A word completing while full with no pop is dropped and sets overflow.
  - Pop on empty has no effect.
  - out_data is stable while out_valid=1 and out_ready=0.
- Health (repetition count):
  - Runs on the combined b of every accepted sample, regardless of mode.
  - Run counter is 1 on the first sample, increments when b equals the previous b, and resets to 1 otherwise. It saturates at RCT_LIMIT.
  - When it reaches RCT_LIMIT, health_fail sets at that edge.
  - While health_fail=1, new pushes are suppressed. Existing FIFO words still drain.
  - health_fail clears only on reset.
- Latency: last contributing ro_in change to out_valid is at most 2 sync cycles + 1 tick period + 1 cycle.

Test Plan:
- RAW, sample_div=0, ch_en=01, ro_in[0] sequence 1,0,1,1,0,0,1,0 one per cycle -> out_data=8'hB2, out_valid=1, fifo_count=1. ro_in[1] toggling randomly has no effect.
- VON_NEUMANN, pairs (0,1),(1,1),(1,0),(0,0),(0,1) x3 -> emits 0,1,0,0,0 in that order. The word completes only after 8 emitted bits. Mode switch to RAW mid-word discards the partial word.
- out_ready=0, DEPTH=4, generate 5 words -> fifo_count=4, overflow=1, out_data=first word. Then with count=4, a push and pop in the same cycle -> count stays 4, overflow unchanged.
- ro_in stuck at 1, RAW, RCT_LIMIT=32 -> health_fail=0 after 31 ticks and 1 after the 32nd. The 4 words already in the FIFO drain; no new words follow.
- sample_div=3, ch_en=11, ro_in=10 constant -> one accepted bit (value 1) every 4 cycles. With ch_en=00 -> no bits, run counter frozen.
- Reset asserted 1 cycle after 5 bits are packed and 2 words are queued -> all outputs 0. The next word requires 8 fresh bits.
